// File: rtl/fc_pkg.sv
// Shared constants and FSM state encoding for the fully-connected MAC engine.
package fc_pkg;

    localparam int DEF_SIZE      = 16;
    localparam int DEF_PRECISION = 11;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        OUT
    } state_t;

endpackage

// File: rtl/fc_sat_relu.sv
// Final result stage: add bias, optional ReLU, then clamp to the signed word range.
module fc_sat_relu #(
    parameter int SIZE  = 16,
    parameter int ACC_W = 34
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic signed [SIZE-1:0]  i_bias,
    input  logic                    i_relu_en,
    output logic [SIZE-1:0]         o_value,
    output logic                    o_sat
);

    // One extra bit so accumulator + bias can never wrap before the clamp.
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((1 <<< (SIZE - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(-(1 <<< (SIZE - 1)));

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_relu;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        o_value = '0;
        o_sat   = 1'b0;
        w_sum   = SUM_W'(i_acc) + SUM_W'(i_bias);
        w_relu  = (i_relu_en && w_sum[SUM_W-1]) ? '0 : w_sum;
        if (w_relu > MAX_V) begin
            o_value = MAX_V[SIZE-1:0];
            o_sat   = 1'b1;
        end else if (w_relu < MIN_V) begin
            o_value = MIN_V[SIZE-1:0];
            o_sat   = 1'b1;
        end else begin
            o_value = w_relu[SIZE-1:0];
        end
    end

endmodule

// File: rtl/fc_mac_engine.sv
// One-neuron fully-connected MAC: LANES products per beat, 2-stage pipeline,
// bias/ReLU/saturation on the result, valid/ready handshakes on both sides.
module fc_mac_engine
    import fc_pkg::*;
#(
    parameter int SIZE      = DEF_SIZE,
    parameter int PRECISION = DEF_PRECISION,
    parameter int LANES     = 4,
    parameter int CNT_W     = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_beats,
    input  logic [SIZE-1:0]         bias,
    input  logic                    relu_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*SIZE-1:0]   in_values,
    input  logic [LANES*SIZE-1:0]   in_weights,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SIZE-1:0]         out_value,
    output logic                    out_sat,
    output logic                    busy
);

    localparam int PROD_W = 2 * SIZE;
    localparam int ACC_W  = 2 * SIZE + $clog2(LANES);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CNT_W-1:0]        r_num_beats;
    logic [CNT_W-1:0]        r_beat_cnt;
    logic signed [SIZE-1:0]  r_bias;
    logic                    r_relu_en;
    logic                    r_drain_cnt;
    logic                    r_p1_valid;
    logic signed [PROD_W-1:0] r_prod [LANES];
    logic signed [PROD_W-1:0] w_prod [LANES];
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_lane_sum;
    logic [SIZE-1:0]         r_out_value;
    logic                    r_out_sat;
    logic [SIZE-1:0]         w_res_value;
    logic                    w_res_sat;
    logic                    w_accept;
    logic                    w_last_beat;

    assign in_ready    = (r_state == ACCUM) && (r_beat_cnt < r_num_beats);
    assign w_accept    = in_valid && in_ready;
    assign w_last_beat = (r_beat_cnt == r_num_beats - CNT_W'(1));
    assign out_valid   = (r_state == OUT);
    assign busy        = (r_state != IDLE);
    assign out_value   = r_out_value;
    assign out_sat     = r_out_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:  if (start) w_next_state = (num_beats == '0) ? DRAIN : ACCUM;
            ACCUM: if (w_accept && w_last_beat) w_next_state = DRAIN;
            DRAIN: if (r_drain_cnt) w_next_state = OUT;
            OUT:   if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Full-width signed products; operands are sign-extended before multiplying.
    always_comb begin
        w_lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_prod[l]  = PROD_W'($signed(in_values[l*SIZE +: SIZE])) *
                         PROD_W'($signed(in_weights[l*SIZE +: SIZE]));
            w_lane_sum = w_lane_sum + ACC_W'(r_prod[l]);
        end
    end

    fc_sat_relu #(
        .SIZE  (SIZE),
        .ACC_W (ACC_W)
    ) u_sat_relu (
        .i_acc     (r_acc),
        .i_bias    (r_bias),
        .i_relu_en (r_relu_en),
        .o_value   (w_res_value),
        .o_sat     (w_res_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the product pipeline is reset too, so an aborted neuron leaves nothing behind.
            for (int l = 0; l < LANES; l++) r_prod[l] <= '0;
            r_p1_valid  <= 1'b0;
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_num_beats <= '0;
            r_bias      <= '0;
            r_relu_en   <= 1'b0;
            r_drain_cnt <= 1'b0;
            r_out_value <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_p1_valid <= w_accept;
            if (w_accept) begin
                for (int l = 0; l < LANES; l++) r_prod[l] <= w_prod[l] >>> PRECISION;
            end
            if (r_p1_valid) r_acc <= r_acc + w_lane_sum;
            r_drain_cnt <= (r_state == DRAIN) ? ~r_drain_cnt : 1'b0;

            unique case (r_state)
                IDLE: if (start) begin
                    r_bias      <= $signed(bias);
                    r_num_beats <= num_beats;
                    r_relu_en   <= relu_en;
                    r_acc       <= '0;
                    r_beat_cnt  <= '0;
                end
                ACCUM: if (w_accept) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                DRAIN: if (r_drain_cnt) begin
                    r_out_value <= w_res_value;
                    r_out_sat   <= w_res_sat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_mac_engine.sv
// Self-checking bench for fc_mac_engine (LANES=2): directed cases plus randomized neurons vs. an arithmetic model.
module tb_fc_mac_engine;

    localparam int SIZE      = 16;
    localparam int PRECISION = 11;
    localparam int LANES     = 2;
    localparam int CNT_W     = 10;
    localparam int MAXB      = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [CNT_W-1:0]      num_beats;
    logic [SIZE-1:0]       bias;
    logic                  relu_en;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*SIZE-1:0] in_values;
    logic [LANES*SIZE-1:0] in_weights;
    logic                  out_valid;
    logic                  out_ready;
    logic [SIZE-1:0]       out_value;
    logic                  out_sat;
    logic                  busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] g_vals [MAXB][LANES];
    logic [15:0] g_wts  [MAXB][LANES];

    fc_mac_engine #(
        .SIZE(SIZE), .PRECISION(PRECISION), .LANES(LANES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_beats(num_beats),
        .bias(bias), .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
        .in_values(in_values), .in_weights(in_weights), .out_valid(out_valid),
        .out_ready(out_ready), .out_value(out_value), .out_sat(out_sat), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer arithmetic with floor division per product.
    function automatic void model(input logic [15:0] bias_w, input bit relu, input int nb,
                                  output logic [15:0] v, output bit s);
        longint acc = 0;
        for (int i = 0; i < nb; i++)
            for (int l = 0; l < LANES; l++)
                acc += (longint'($signed(g_vals[i][l])) * longint'($signed(g_wts[i][l]))) >>> PRECISION;
        acc += longint'($signed(bias_w));
        if (relu && acc < 0) acc = 0;
        s = 1'b0;
        if (acc > 32767) begin
            v = 16'h7FFF; s = 1'b1;
        end else if (acc < -32768) begin
            v = 16'h8000; s = 1'b1;
        end else begin
            v = acc[15:0];
        end
    endfunction

    task automatic set_beat(input int i, input logic [15:0] v0, input logic [15:0] v1,
                            input logic [15:0] w0, input logic [15:0] w1);
        g_vals[i][0] = v0; g_vals[i][1] = v1;
        g_wts[i][0]  = w0; g_wts[i][1]  = w1;
    endtask

    // Starts a neuron, feeds nb beats with gap idle cycles between them, and
    // returns the number of edges from the last acceptance to out_valid.
    task automatic run_to_out(input int nb, input logic [15:0] b, input bit relu,
                              input int gap, output int lat);
        int t;
        start = 1'b1; num_beats = CNT_W'(nb); bias = b; relu_en = relu;
        tick();
        start = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (i > 0) for (int g = 0; g < gap; g++) tick();
            in_valid   = 1'b1;
            in_values  = {g_vals[i][1], g_vals[i][0]};
            in_weights = {g_wts[i][1], g_wts[i][0]};
            t = 0;
            while (!in_ready && t < 20) begin tick(); t++; end
            tick();
            in_valid = 1'b0;
        end
        in_values = '0; in_weights = '0;
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_beats = '0; bias = '0; relu_en = 1'b0;
        in_valid = 1'b0; in_values = '0; in_weights = '0; out_ready = 1'b0;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_value !== 16'h0000) begin errors++; $display("FAIL reset_out_value: got %h want 0000", out_value); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        int lat;
        set_beat(0, 16'h0800, 16'h0400, 16'h1800, 16'h2000);
        run_to_out(1, 16'h0C00, 1'b0, 0, lat);
        checks++; if (out_value !== 16'h3400) begin errors++; $display("FAIL six_five_value: got %h want 3400", out_value); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL six_five_sat: got %b want 0", out_sat); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL six_five_latency: got %0d want 2", lat); end
        consume();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL six_five_release: got valid=%b busy=%b want 0 0", out_valid, busy); end

        set_beat(0, 16'h0800, 16'h0800, 16'h0800, 16'h0800);
        set_beat(1, 16'h0800, 16'h0800, 16'h0800, 16'h0800);
        run_to_out(2, 16'h0800, 1'b0, 3, lat);
        checks++; if (out_value !== 16'h2800) begin errors++; $display("FAIL gaps_value: got %h want 2800", out_value); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL gaps_latency: got %0d want 2", lat); end
        consume();

        set_beat(0, 16'h7800, 16'h7800, 16'h0800, 16'h0800);
        set_beat(1, 16'h7800, 16'h7800, 16'h0800, 16'h0800);
        run_to_out(2, 16'h0000, 1'b0, 0, lat);
        checks++; if (out_value !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_value: got %h want 7fff", out_value); end
        checks++; if (out_sat !== 1'b1) begin errors++; $display("FAIL sat_pos_flag: got %b want 1", out_sat); end
        consume();

        set_beat(0, 16'h7800, 16'h7800, 16'hF800, 16'hF800);
        set_beat(1, 16'h7800, 16'h7800, 16'hF800, 16'hF800);
        run_to_out(2, 16'h0000, 1'b0, 0, lat);
        checks++; if (out_value !== 16'h8000) begin errors++; $display("FAIL sat_neg_value: got %h want 8000", out_value); end
        checks++; if (out_sat !== 1'b1) begin errors++; $display("FAIL sat_neg_flag: got %b want 1", out_sat); end
        consume();

        run_to_out(0, 16'hF800, 1'b1, 0, lat);
        checks++; if (out_value !== 16'h0000) begin errors++; $display("FAIL relu_on_value: got %h want 0000", out_value); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL relu_on_sat: got %b want 0", out_sat); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL zero_beats_latency: got %0d want 2", lat); end
        consume();

        run_to_out(0, 16'hF800, 1'b0, 0, lat);
        checks++; if (out_value !== 16'hF800) begin errors++; $display("FAIL relu_off_value: got %h want f800", out_value); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL relu_off_sat: got %b want 0", out_sat); end
        consume();
    endtask

    task automatic test_reset_mid_accum();
        int lat;
        logic [15:0] exp_v;
        bit exp_s;
        for (int i = 0; i < 3; i++)
            set_beat(i, 16'h1000, 16'h0C00, 16'h0A00, 16'hF400);
        start = 1'b1; num_beats = CNT_W'(3); bias = 16'h0400; relu_en = 1'b0;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_values = {g_vals[0][1], g_vals[0][0]};
        in_weights = {g_wts[0][1], g_wts[0][0]};
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_value !== 16'h0000) begin errors++; $display("FAIL midrst_out_value: got %h want 0000", out_value); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL midrst_out_sat: got %b want 0", out_sat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_no_output: got valid=%b busy=%b want 0 0", out_valid, busy); end
        end
        set_beat(0, 16'h0800, 16'h1000, 16'h0400, 16'h0C00);
        set_beat(1, 16'hF000, 16'h0200, 16'h0800, 16'h0800);
        model(16'h0200, 1'b0, 2, exp_v, exp_s);
        run_to_out(2, 16'h0200, 1'b0, 0, lat);
        checks++; if (out_value !== exp_v) begin errors++; $display("FAIL midrst_next_value: got %h want %h", out_value, exp_v); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] exp_v;
        bit exp_s;
        set_beat(0, 16'h1200, 16'hF600, 16'h0900, 16'h1100);
        model(16'h0300, 1'b0, 1, exp_v, exp_s);
        run_to_out(1, 16'h0300, 1'b0, 0, lat);
        for (int c = 0; c < 5; c++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d: got %b want 1", c, out_valid); end
            checks++; if (out_value !== exp_v || out_sat !== exp_s) begin errors++; $display("FAIL bp_value_c%0d: got %h/%b want %h/%b", c, out_value, out_sat, exp_v, exp_s); end
            start = (c % 2 == 0); num_beats = '0;
            tick();
        end
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_start_ignored: got busy=%b valid=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_random();
        int lat, nb, gap;
        logic [15:0] b, r, exp_v;
        bit relu, exp_s, full;
        for (int n = 0; n < 25; n++) begin
            nb = $urandom_range(0, 6);
            gap = $urandom_range(0, 2);
            relu = 1'($urandom_range(0, 1));
            full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < nb; i++)
                for (int l = 0; l < LANES; l++) begin
                    r = 16'($urandom);
                    g_vals[i][l] = full ? r : {{3{r[12]}}, r[12:0]};
                    r = 16'($urandom);
                    g_wts[i][l]  = full ? r : {{3{r[12]}}, r[12:0]};
                end
            r = 16'($urandom);
            b = full ? r : {{2{r[13]}}, r[13:0]};
            model(b, relu, nb, exp_v, exp_s);
            run_to_out(nb, b, relu, gap, lat);
            checks++; if (out_value !== exp_v) begin errors++; $display("FAIL rand%0d_value: got %h want %h", n, out_value, exp_v); end
            checks++; if (out_sat !== exp_s) begin errors++; $display("FAIL rand%0d_sat: got %b want %b", n, out_sat, exp_s); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL rand%0d_latency: got %0d want 2", n, lat); end
            for (int d = $urandom_range(0, 2); d > 0; d--) tick();
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_accum();
        test_backpressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
